pci_arbiter: RTL

Central PCI bus arbiter for the three device ports of the PCI pin multiplexer. It consumes the per-port REQ# lines and the bus FRAME#/IRDY# inputs, and produces the GNT# lines the multiplexer samples.
- Round-robin between masters 0..2.
- Enforces the idle-bus turnaround gap between grants.
- Revokes grants left unused past a timeout.
- Optionally parks the bus on the last owner.

---
 rtl/pci_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin GNT# for three masters, idle-bus turnaround gap, unused-grant timeout.
// Latency: 1 cycle from sampled REQ# to GNT# (2 cycles from a parked grant on another master); all outputs registered.
// Backpressure: none; masters hold REQ# until granted, and a grant left unused on an idle bus is revoked. Optional macro: PCI_ARB_PARK_EN.
module pci_arbiter #(
  parameter int GNT_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_n,
  input  logic       frame_n,
  input  logic       irdy_n,
  output logic [2:0] gnt_n,
  output logic [1:0] owner,
  output logic       gnt_valid,
  output logic       bus_idle,
  output logic       timeout_p
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GNT  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [4:0] TO_LAST = 5'(GNT_TIMEOUT - 1);

  logic [1:0] r_state, r_owner, r_last;
  logic [4:0] r_cnt;
  logic [2:0] r_gnt_n;
  logic       r_gnt_valid, r_bus_idle, r_timeout_p;

  logic [1:0] w_state_nx, w_owner_nx, w_last_nx;
  logic [4:0] w_cnt_nx;
  logic [2:0] w_gnt_nx;
  logic       w_to_nx;

  logic [2:0] w_req;
  logic       w_idle_c, w_start, w_any, w_oth_any;
  logic [1:0] w_c1, w_c2, w_o1, w_o2, w_win, w_oth;

  // Active-low GNT# vector for one master index.
  function automatic logic [2:0] gnt_of(input logic [1:0] idx);
    return 3'b111 ^ (3'b001 << idx);
  endfunction

  // Request bit lookup that never indexes past bit 2.
  function automatic logic bit_at(input logic [2:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    return v[0];
      2'd1:    return v[1];
      default: return v[2];
    endcase
  endfunction

  assign w_req    = ~req_n;
  assign w_idle_c = frame_n & irdy_n;
  // A start is FRAME# falling on a bus that was idle the cycle before.
  assign w_start  = ~frame_n & r_bus_idle;
  assign w_any    = |w_req;

  // Round-robin candidates: from last_owner for fresh grants, from the current owner for BUSY handoff.
  always_comb begin
    w_c1 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    w_c2 = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    w_o1 = (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
    w_o2 = (w_o1 == 2'd2) ? 2'd0 : w_o1 + 2'd1;
    if (bit_at(w_req, w_c1))      w_win = w_c1;
    else if (bit_at(w_req, w_c2)) w_win = w_c2;
    else                          w_win = r_last;
    w_oth_any = bit_at(w_req, w_o1) | bit_at(w_req, w_o2);
    w_oth     = bit_at(w_req, w_o1) ? w_o1 : w_o2;
  end

  // Next-state, next-grant and timeout decision.
  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_last_nx  = r_last;
    w_cnt_nx   = r_cnt;
    w_gnt_nx   = r_gnt_n;
    w_to_nx    = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef PCI_ARB_PARK_EN
        // Parked on the current owner; a different winner must pass through GAP.
        w_gnt_nx = gnt_of(r_owner);
        if (w_start) begin
          w_state_nx = S_BUSY;
          w_last_nx  = r_owner;
        end else if (bit_at(w_req, r_owner)) begin
          w_state_nx = S_GNT;
          w_last_nx  = r_owner;
          w_cnt_nx   = 5'd0;
        end else if (w_any) begin
          w_state_nx = S_GAP;
          w_gnt_nx   = 3'b111;
        end
`else
        w_gnt_nx = 3'b111;
        if (w_any) begin
          w_state_nx = S_GNT;
          w_owner_nx = w_win;
          w_last_nx  = w_win;
          w_cnt_nx   = 5'd0;
          w_gnt_nx   = gnt_of(w_win);
        end
`endif
      end
      S_GNT: begin
        // Start beats timeout, timeout beats request withdrawal.
        if (w_start) begin
          w_state_nx = S_BUSY;
        end else if (w_idle_c && (r_cnt == TO_LAST)) begin
          w_state_nx = S_GAP;
          w_gnt_nx   = 3'b111;
          w_to_nx    = 1'b1;
        end else if (w_idle_c && !bit_at(w_req, r_owner)) begin
          if (w_any) begin
            w_state_nx = S_GAP;
            w_gnt_nx   = 3'b111;
          end else begin
            w_state_nx = S_IDLE;
`ifdef PCI_ARB_PARK_EN
            w_gnt_nx   = gnt_of(r_owner);
`else
            w_gnt_nx   = 3'b111;
`endif
          end
        end else if (w_idle_c) begin
          w_cnt_nx = r_cnt + 5'd1;
        end
      end
      S_BUSY: begin
        // The bus is driven by the current transaction, so the next grant needs no gap.
        if (w_oth_any) begin
          w_state_nx = S_GNT;
          w_owner_nx = w_oth;
          w_last_nx  = w_oth;
          w_cnt_nx   = 5'd0;
          w_gnt_nx   = gnt_of(w_oth);
        end else if (w_idle_c) begin
          if (bit_at(w_req, r_owner)) begin
            w_state_nx = S_GNT;
            w_cnt_nx   = 5'd0;
          end else begin
            w_state_nx = S_IDLE;
`ifdef PCI_ARB_PARK_EN
            w_gnt_nx   = gnt_of(r_owner);
`else
            w_gnt_nx   = 3'b111;
`endif
          end
        end
      end
      default: begin
        // GAP: exactly one cycle with every GNT# high.
        if (w_any) begin
          w_state_nx = S_GNT;
          w_owner_nx = w_win;
          w_last_nx  = w_win;
          w_cnt_nx   = 5'd0;
          w_gnt_nx   = gnt_of(w_win);
        end else begin
          w_state_nx = S_IDLE;
`ifdef PCI_ARB_PARK_EN
          w_gnt_nx   = gnt_of(r_owner);
`else
          w_gnt_nx   = 3'b111;
`endif
        end
      end
    endcase
  end

  // State and output registers; reset leaves last_owner at 2 so master 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_owner     <= 2'd0;
      r_last      <= 2'd2;
      r_cnt       <= 5'd0;
      r_gnt_n     <= 3'b111;
      r_gnt_valid <= 1'b0;
      r_bus_idle  <= 1'b1;
      r_timeout_p <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_owner     <= w_owner_nx;
      r_last      <= w_last_nx;
      r_cnt       <= w_cnt_nx;
      r_gnt_n     <= w_gnt_nx;
      r_gnt_valid <= (w_gnt_nx != 3'b111);
      r_bus_idle  <= w_idle_c;
      r_timeout_p <= w_to_nx;
    end
  end

  assign gnt_n     = r_gnt_n;
  assign owner     = r_owner;
  assign gnt_valid = r_gnt_valid;
  assign bus_idle  = r_bus_idle;
  assign timeout_p = r_timeout_p;

endmodule
